// File: rtl/gon_pkg.sv
// rtl/gon_pkg.sv - shared widths, FSM states and rotated first-one search for the gather bus
package gon_pkg;

  localparam int ID_BITWIDTH_DEF        = 4;
  localparam int PACKET_IN_BITWIDTH_DEF = 8;
  localparam int RR_MAX_N               = 32;

  typedef enum logic {
    IDLE,
    OWNED
  } gon_state_e;

  // First set bit of req[n-1:0] at index start, start+1, ... wrapping mod n (start in 0..n); -1 if none.
  function automatic int rr_first(input logic [RR_MAX_N-1:0] req, input int n, input int start);
    logic [2*RR_MAX_N-1:0] dbl;
    int                    idx;
    dbl      = ({{RR_MAX_N{1'b0}}, req} | ({{RR_MAX_N{1'b0}}, req} << n)) >> start;
    idx      = 0;
    rr_first = -1;
    for (int i = RR_MAX_N - 1; i >= 0; i--) begin
      if (i < n && dbl[i]) begin
        idx      = start + i;
        rr_first = (idx >= n) ? idx - n : idx;
      end
    end
  endfunction

endpackage

// File: rtl/gon_rr_arb.sv
// rtl/gon_rr_arb.sv - burst-limited round-robin arbiter; owner register doubles as the priority pointer
module gon_rr_arb
  import gon_pkg::*;
#(
  parameter int N         = 6,
  parameter int BURST_MAX = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         can_accept_i,
  output logic [N-1:0] grant_o
);

  localparam int OW = $clog2(N);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

  gon_state_e          state_q, state_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [BW-1:0]       burst_q, burst_d;
  logic [RR_MAX_N-1:0] req_ext;
  logic                keep;
  logic                xfer;
  int                  pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req_i;
    grant_o        = '0;
    state_d        = state_q;
    owner_d        = owner_q;
    burst_d        = burst_q;

    // owner_q holds the last owner even in IDLE, so the scan always resumes after it
    keep = (state_q == OWNED) && req_i[owner_q] && (burst_q < BURST_LIM);
    pick = keep ? int'(owner_q) : rr_first(req_ext, N, int'(owner_q) + 1);
    for (int k = 0; k < N; k++) grant_o[k] = (pick == k);
    xfer = (pick >= 0) && can_accept_i;

    if (xfer) begin
      state_d = OWNED;
      owner_d = OW'(pick);
      if (state_q == IDLE || owner_q != OW'(pick) || burst_q == BURST_LIM) burst_d = BW'(1);
      else burst_d = burst_q + BW'(1);
    end else if (req_i == '0 && can_accept_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= OW'(N - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/gon_gather_bus.sv
// rtl/gon_gather_bus.sv - N-to-1 gather bus with ID prefixing; GON_ID_FILTER_EN restricts winners to id==i_tag
module gon_gather_bus
  import gon_pkg::*;
#(
  parameter int ID_BITWIDTH         = ID_BITWIDTH_DEF,
  parameter int PACKET_IN_BITWIDTH  = PACKET_IN_BITWIDTH_DEF,
  parameter int PACKET_OUT_BITWIDTH = 12,
  parameter int SLV_NUM             = 6,
  parameter int BURST_MAX           = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [SLV_NUM*PACKET_IN_BITWIDTH-1:0] i_packet,
  input  logic [SLV_NUM-1:0]                i_valid,
  output logic [SLV_NUM-1:0]                o_ready,
  output logic [PACKET_OUT_BITWIDTH-1:0]    o_packet,
  output logic                              o_valid,
  input  logic                              i_ready,
  input  logic [SLV_NUM*ID_BITWIDTH-1:0]    i_id,
  input  logic                              i_id_valid,
  input  logic [ID_BITWIDTH-1:0]            i_tag
);

  logic [ID_BITWIDTH-1:0]         id_q [SLV_NUM];
  logic                           cfg_done_q;
  logic                           can_accept;
  logic                           xfer;
  logic [SLV_NUM-1:0]             tag_ok;
  logic [SLV_NUM-1:0]             req;
  logic [SLV_NUM-1:0]             grant;
  logic [PACKET_OUT_BITWIDTH-1:0] sel_packet;

`ifdef GON_ID_FILTER_EN
  always_comb begin
    tag_ok = '0;
    for (int k = 0; k < SLV_NUM; k++) tag_ok[k] = (id_q[k] == i_tag);
  end
`else
  logic unused_tag;
  assign tag_ok     = '1;
  assign unused_tag = ^i_tag;
`endif

  assign can_accept = !o_valid || i_ready;
  assign o_ready    = grant & {SLV_NUM{can_accept}};
  assign xfer       = |(i_valid & o_ready);

  always_comb begin
    req        = '0;
    sel_packet = '0;
    for (int k = 0; k < SLV_NUM; k++) begin
      req[k] = i_valid[k] && cfg_done_q && tag_ok[k];
      if (grant[k]) sel_packet = {id_q[k], i_packet[k*PACKET_IN_BITWIDTH +: PACKET_IN_BITWIDTH]};
    end
  end

  gon_rr_arb #(
    .N        (SLV_NUM),
    .BURST_MAX(BURST_MAX)
  ) u_arb (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .req_i       (req),
    .can_accept_i(can_accept),
    .grant_o     (grant)
  );

  // a transfer in the same cycle as i_id_valid still sees the old id_q
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_packet   <= '0;
      cfg_done_q <= 1'b0;
      for (int k = 0; k < SLV_NUM; k++) id_q[k] <= '0;
    end else begin
      if (i_id_valid) begin
        cfg_done_q <= 1'b1;
        for (int k = 0; k < SLV_NUM; k++) id_q[k] <= i_id[k*ID_BITWIDTH +: ID_BITWIDTH];
      end
      if (xfer) begin
        o_valid  <= 1'b1;
        o_packet <= sel_packet;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gon_gather_bus.sv
// tb/tb_gon_gather_bus.sv - randomized scoreboard bench for gon_gather_bus
module tb_gon_gather_bus;

  localparam int N     = 6;
  localparam int IDW   = 4;
  localparam int PW    = 8;
  localparam int OW    = 12;
  localparam int BURST = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*PW-1:0]   pkt;
  logic [N-1:0]      vld;
  logic [N-1:0]      o_ready;
  logic [OW-1:0]     o_packet;
  logic              o_valid;
  logic              rdy;
  logic [N*IDW-1:0]  ids;
  logic              idv;
  logic [IDW-1:0]    tag;

  logic [N-1:0]      acc;
  logic [N-1:0]      dut_rdy;
  int                checks = 0;
  int                errors = 0;

  int                m_owner;
  int                m_last;
  int                m_cnt;
  bit                m_cfg;
  bit                m_ov;
  logic [N*IDW-1:0]  m_ids;
  logic [OW-1:0]     sb[$];

  always #5 clk = ~clk;

  gon_gather_bus #(
    .ID_BITWIDTH        (IDW),
    .PACKET_IN_BITWIDTH (PW),
    .PACKET_OUT_BITWIDTH(OW),
    .SLV_NUM            (N),
    .BURST_MAX          (BURST)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_packet  (pkt),
    .i_valid   (vld),
    .o_ready   (o_ready),
    .o_packet  (o_packet),
    .o_valid   (o_valid),
    .i_ready   (rdy),
    .i_id      (ids),
    .i_id_valid(idv),
    .i_tag     (tag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_cnt   = 0;
    m_cfg   = 0;
    m_ov    = 0;
    m_ids   = '0;
    acc     = '0;
    sb.delete();
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return |(v & (N'(1) << i));
  endfunction

  // Owner keeps the bus while it requests and has burst budget; otherwise scan after the last owner.
  function automatic int model_pick(input logic [N-1:0] req);
    if (m_owner >= 0 && bit_of(req, m_owner) && m_cnt < BURST) return m_owner;
    for (int d = 1; d <= N; d++) if (bit_of(req, (m_last + d) % N)) return (m_last + d) % N;
    return -1;
  endfunction

  task automatic step();
    logic [N-1:0] req;
    logic [N-1:0] exp_rdy;
    int           g;
    bit           ca;
    #2;
    req = '0;
    for (int k = 0; k < N; k++) begin
      req[k] = vld[k] && m_cfg;
`ifdef GON_ID_FILTER_EN
      req[k] = req[k] && (IDW'(m_ids >> (k*IDW)) == tag);
`endif
    end
    ca      = !m_ov || rdy;
    g       = model_pick(req);
    exp_rdy = (g >= 0 && ca) ? (N'(1) << g) : '0;
    dut_rdy = o_ready;
    check("o_ready", 32'(o_ready), 32'(exp_rdy));
    acc = exp_rdy;
    if (exp_rdy != '0) begin
      sb.push_back({IDW'(m_ids >> (g*IDW)), PW'(pkt >> (g*PW))});
      m_cnt   = (g != m_owner) ? 1 : ((m_cnt == BURST) ? 1 : m_cnt + 1);
      m_owner = g;
      m_last  = g;
      m_ov    = 1;
    end else begin
      if (req == '0 && ca) m_owner = -1;
      if (rdy) m_ov = 0;
    end
    if (idv) begin
      m_cfg = 1;
      m_ids = ids;
    end
    @(posedge clk);
    #1;
  endtask

  // Slaves hold valid/payload until accepted; idle or just-accepted slaves draw new stimulus.
  task automatic refresh(input logic [N-1:0] mask, input int prob);
    for (int k = 0; k < N; k++) begin
      if (acc[k] || !vld[k]) begin
        vld[k]          = mask[k] && (int'($urandom_range(0, 99)) < prob);
        pkt[k*PW +: PW] = PW'($urandom);
      end
    end
    acc = '0;
  endtask

  task automatic reset_and_load(input logic [N*IDW-1:0] new_ids);
    vld = '0;
    idv = 1'b0;
    rdy = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    ids = new_ids;
    idv = 1'b1;
    step();
    idv = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid && rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL o_packet: got beat 0x%0h expected none at %0t", o_packet, $time);
      end else begin
        check("o_packet", 32'(o_packet), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1;
    vld = '0;
    pkt = '0;
    rdy = 1'b1;
    idv = 1'b0;
    ids = '0;
    tag = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset o_valid", 32'(o_valid), 32'h0);
    check("reset o_ready", 32'(o_ready), 32'h0);
    check("reset o_packet", 32'(o_packet), 32'h0);

    // no grants before the IDs are configured
    refresh('1, 100);
    repeat (3) step();
    ids = 24'hA98765;
    idv = 1'b1;
    step();
    idv = 1'b0;
    step();
    check("cfg first grant", 32'(dut_rdy), 32'h1);

    reset_and_load(24'hA98765);
    refresh(6'b000101, 100);
    for (int i = 0; i < 16; i++) begin
      step();
      check("burst order", 32'(dut_rdy), (((i / 4) % 2) == 0) ? 32'h1 : 32'h4);
      refresh(6'b000101, 100);
    end

    reset_and_load(24'hA98765);
    refresh(6'b001000, 100);
    for (int i = 0; i < 10; i++) begin
      step();
      check("sole requester", 32'(dut_rdy), 32'h8);
      refresh(6'b001000, 100);
    end

    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall o_ready", 32'(dut_rdy), 32'h0);
      check("stall o_valid", 32'(o_valid), 32'h1);
      if (sb.size() != 0) check("stall o_packet", 32'(o_packet), 32'(sb[0]));
      else check("stall pending beat", 32'(sb.size()), 32'h1);
      refresh(6'b001000, 100);
    end
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("resume", 32'(dut_rdy), 32'h8);
      refresh(6'b001000, 100);
    end

`ifdef GON_ID_FILTER_EN
    tag = 4'h2;
    reset_and_load(24'h212121);
    refresh('1, 100);
    for (int i = 0; i < 12; i++) begin
      step();
      check("filter grant", 32'(dut_rdy & 6'b010101), 32'h0);
      refresh('1, 100);
    end
    tag = 4'h0;
`endif

    // reset lands on the second beat of a burst
    reset_and_load(24'hA98765);
    refresh(6'b000001, 100);
    step();
    refresh(6'b000001, 100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check("midreset o_valid", 32'(o_valid), 32'h0);
    check("midreset o_ready", 32'(o_ready), 32'h0);
    refresh('1, 100);
    ids = 24'hA98765;
    idv = 1'b1;
    step();
    idv = 1'b0;
    refresh('1, 100);
    step();
    check("midreset first grant", 32'(dut_rdy), 32'h1);
    refresh('1, 100);

    reset_and_load(24'($urandom));
    for (int i = 0; i < 1500; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      idv = ($urandom_range(0, 63) == 0);
      if (idv) ids = 24'($urandom);
      tag = IDW'($urandom_range(0, 3));
      step();
      idv = 1'b0;
      refresh('1, int'($urandom_range(10, 90)));
    end

    rdy = 1'b1;
    for (int i = 0; i < 100 && (sb.size() != 0 || vld != '0); i++) begin
      step();
      refresh('0, 0);
    end
    check("drain scoreboard", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
